// File: rtl/riscv_pkg.sv
// Shared decode definitions: opcodes, FSM states,
// immediate formats and the decode-to-execute bundle.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/riscv_decode_if.sv
// Fetch, writeback and execute handshakes of the decode stage.
// master = surrounding pipeline, slave = decode stage.
interface riscv_decode_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc,
    output wb_valid, wb_rd, wb_data,
    output out_ready,
    input  in_ready, wb_ready, out_valid,
    input  out_pc, out_opcode, out_funct3,
    input  out_funct7, out_rd, out_rs1_val,
    input  out_rs2_val, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  wb_valid, wb_rd, wb_data,
    input  out_ready,
    output in_ready, wb_ready, out_valid,
    output out_pc, out_opcode, out_funct3,
    output out_funct7, out_rd, out_rs1_val,
    output out_rs2_val, out_imm, out_illegal
  );

endinterface

// File: rtl/riscv_imm_gen.sv
// Immediate generator: instr in; sign-extended imm and
// illegal flag out. Unknown opcodes give imm=0.
module riscv_imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0] op;
  imm_fmt_t   fmt;
  logic       known;

  assign op = instr[6:0];

  always_comb begin
    fmt   = IMM_NONE;
    known = 1'b1;
    unique case (1'b1)
      (op == OP_LOAD),
      (op == OP_OPIMM),
      (op == OP_JALR),
      (op == OP_SYSTEM),
      (op == OP_MISC):   fmt = IMM_I;
      (op == OP_STORE):  fmt = IMM_S;
      (op == OP_BRANCH): fmt = IMM_B;
      (op == OP_LUI),
      (op == OP_AUIPC):  fmt = IMM_U;
      (op == OP_JAL):    fmt = IMM_J;
      (op == OP_OP):     fmt = IMM_NONE;
      default:           known = 1'b0;
    endcase
  end

  assign illegal = ~known | (instr[1:0] != 2'b11);

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I: imm = {{20{instr[31]}},
                    instr[31:20]};
      IMM_S: imm = {{20{instr[31]}},
                    instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31],
                    instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31],
                    instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_decode.sv
// Decode stage: fetch/wb/execute via bus (slave), register
// file via rf_* (read addr/strobe out, rf_a/rf_b data in).
module riscv_decode
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  riscv_decode_if.slave bus,
  output logic        rf_cs,
  output logic [4:0]  rf_ra,
  output logic [4:0]  rf_rb,
  output logic [4:0]  rf_rd,
  output logic        rf_wen,
  output logic [31:0] rf_data,
  input  logic [31:0] rf_a,
  input  logic [31:0] rf_b
);

  state_t      st, st_nx;
  logic        live;
  logic [31:0] ir, pc;
  id_ex_t      ex;
  logic [31:0] imm;
  logic        ill;
  logic        in_rdy, acc;
  logic        wb_srv, rd_srv;
  logic [4:0]  rs1, rs2, rd;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  riscv_imm_gen u_imm (
    .instr   (ir),
    .imm     (imm),
    .illegal (ill)
  );

  // live holds handshakes low until the first edge out of reset
  assign in_rdy = live & ((st == S_IDLE) |
                  ((st == S_HOLD) & bus.out_ready));
  assign acc    = in_rdy & bus.in_valid;
  assign wb_srv = live & bus.wb_valid & (st != S_WAIT);
  assign rd_srv = (st == S_ISSUE) & ~bus.wb_valid;

  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE:  if (acc) st_nx = S_ISSUE;
      S_ISSUE: if (rd_srv) st_nx = S_WAIT;
      S_WAIT:  st_nx = S_HOLD;
      S_HOLD:
        if (bus.out_ready)
          st_nx = acc ? S_ISSUE : S_IDLE;
      default: st_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rf_cs   = 1'b0;
    rf_wen  = 1'b0;
    rf_ra   = '0;
    rf_rb   = '0;
    rf_rd   = '0;
    rf_data = '0;
    if (wb_srv) begin
      // x0 writes are acknowledged but never reach the file
      if (bus.wb_rd != 5'd0) begin
        rf_cs   = 1'b1;
        rf_wen  = 1'b1;
        rf_rd   = bus.wb_rd;
        rf_data = bus.wb_data;
      end
    end else if (rd_srv) begin
      rf_cs = 1'b1;
      rf_ra = rs1;
      rf_rb = rs2;
      rf_rd = rd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st   <= S_IDLE;
      live <= 1'b0;
      ir   <= '0;
      pc   <= '0;
      ex   <= '0;
    end else begin
      st   <= st_nx;
      live <= 1'b1;
      if (acc) begin
        ir <= bus.in_instr;
        pc <= bus.in_pc;
      end
      if (st == S_WAIT) begin
        ex.pc      <= pc;
        ex.opcode  <= ir[6:0];
        ex.funct3  <= ir[14:12];
        ex.funct7  <= ir[31:25];
        ex.rd      <= rd;
        ex.rs1_val <= (rs1 == 5'd0) ? '0 : rf_a;
        ex.rs2_val <= (rs2 == 5'd0) ? '0 : rf_b;
        ex.imm     <= imm;
        ex.illegal <= ill;
      end
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.wb_ready    = wb_srv;
  assign bus.out_valid   = (st == S_HOLD);
  assign bus.out_pc      = ex.pc;
  assign bus.out_opcode  = ex.opcode;
  assign bus.out_funct3  = ex.funct3;
  assign bus.out_funct7  = ex.funct7;
  assign bus.out_rd      = ex.rd;
  assign bus.out_rs1_val = ex.rs1_val;
  assign bus.out_rs2_val = ex.rs2_val;
  assign bus.out_imm     = ex.imm;
  assign bus.out_illegal = ex.illegal;

endmodule

// File: tb/tb_riscv_decode.sv
// Bench for riscv_decode: register-file model, directed
// instructions, scoreboard-checked execute bundles.
module tb_riscv_decode;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rf_cs, rf_wen;
  logic [4:0]  rf_ra, rf_rb, rf_rd;
  logic [31:0] rf_data, rf_a, rf_b;
  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;
  int lat;

  id_ex_t sb [$];
  id_ex_t e, act;

  riscv_decode_if bus ();

  riscv_decode dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .rf_cs   (rf_cs),
    .rf_ra   (rf_ra),
    .rf_rb   (rf_rb),
    .rf_rd   (rf_rd),
    .rf_wen  (rf_wen),
    .rf_data (rf_data),
    .rf_a    (rf_a),
    .rf_b    (rf_b)
  );

  always #5 clk = ~clk;

  // register file stand-in; nonzero x0 exposes missing rs=0 forcing
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (rf_cs) begin
      if (rf_wen) mem[rf_rd] <= rf_data;
      else begin
        rf_a <= mem[rf_ra];
        rf_b <= mem[rf_rb];
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready) begin
      act = '{bus.out_pc, bus.out_opcode,
              bus.out_funct3, bus.out_funct7,
              bus.out_rd, bus.out_rs1_val,
              bus.out_rs2_val, bus.out_imm,
              bus.out_illegal};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bundle: unexpected pc=%h",
                 bus.out_pc);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL bundle pc=%h: got %h need %h",
                   e.pc, act, e);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h need %h", nm, a, x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins,
                       input logic [31:0] pc);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    #1;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 1;
    while (!bus.out_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic [6:0] op,
                      input logic [2:0] f3,
                      input logic [6:0] f7,
                      input logic [4:0] rd,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] imm,
                      input logic ill);
    id_ex_t x;
    x = '{pc, op, f3, f7, rd, a, b, imm, ill};
    sb.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst rf_cs", 32'(rf_cs), 0);
    chk("rst wb_ready", 32'(bus.wb_ready), 0);
    chk("rst in_ready", 32'(bus.in_ready), 0);
    chk("rst out_imm", bus.out_imm, 0);
    rstn = 1'b1;
    tick();
    chk("in_ready post rst", 32'(bus.in_ready), 1);

    // preload x1 = 10 from IDLE
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.wb_data  = 32'd10;
    #1;
    chk("pre wb_ready", 32'(bus.wb_ready), 1);
    chk("pre rf_cs", 32'(rf_cs), 1);
    chk("pre rf_wen", 32'(rf_wen), 1);
    chk("pre rf_rd", 32'(rf_rd), 1);
    chk("pre rf_data", rf_data, 10);
    chk("pre rf_ra", 32'(rf_ra), 0);
    tick();
    bus.wb_valid = 1'b0;

    // addi x5,x1,-3
    push(32'h100, 7'h13, 3'd0, 7'h7F, 5'd5,
         32'd10, 32'hA000_001D, 32'hFFFF_FFFD, 1'b0);
    issue(32'hFFD0_8293, 32'h100);
    wait_out(lat);
    chk("addi latency", 32'(lat), 3);
    tick();

    // add x6,x2,x1 with two writes of x2 during ISSUE
    push(32'h104, 7'h33, 3'd0, 7'h00, 5'd6,
         32'h55, 32'd10, 32'd0, 1'b0);
    issue(32'h0011_0333, 32'h104);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd2;
    bus.wb_data  = 32'h55;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("col wb_ready", 32'(bus.wb_ready), 1);
      chk("col rf_wen", 32'(rf_wen), 1);
      chk("col rf_rd", 32'(rf_rd), 2);
      tick();
    end
    bus.wb_valid = 1'b0;
    #1;
    chk("col rd rf_cs", 32'(rf_cs), 1);
    chk("col rd rf_wen", 32'(rf_wen), 0);
    chk("col rd rf_ra", 32'(rf_ra), 2);
    chk("col rd rf_rb", 32'(rf_rb), 1);
    chk("col rd rf_rd", 32'(rf_rd), 6);
    chk("col N+3 valid", 32'(bus.out_valid), 0);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    bus.wb_data  = 32'h77;
    #1;
    chk("wait wb_ready", 32'(bus.wb_ready), 0);
    chk("wait rf_cs", 32'(rf_cs), 0);
    chk("col N+4 valid", 32'(bus.out_valid), 0);
    tick();
    chk("col N+5 valid", 32'(bus.out_valid), 1);
    chk("hold wb_ready", 32'(bus.wb_ready), 1);
    tick();
    bus.wb_valid = 1'b0;

    // write to x0 is dropped
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'hFFFF_FFFF;
    #1;
    chk("x0 wb_ready", 32'(bus.wb_ready), 1);
    chk("x0 rf_cs", 32'(rf_cs), 0);
    tick();
    bus.wb_valid = 1'b0;
    push(32'h108, 7'h33, 3'd0, 7'h00, 5'd3,
         32'd0, 32'd0, 32'd0, 1'b0);
    issue(32'h0000_01B3, 32'h108);
    wait_out(lat);
    chk("add latency", 32'(lat), 3);
    tick();

    // beq x0,x0,-4
    push(32'h10C, 7'h63, 3'd0, 7'h7F, 5'd29,
         32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0);
    issue(32'hFE00_0EE3, 32'h10C);
    wait_out(lat);
    tick();

    // sw x1,8(x2)
    push(32'h110, 7'h23, 3'd2, 7'h00, 5'd8,
         32'h55, 32'd10, 32'd8, 1'b0);
    issue(32'h0011_2423, 32'h110);
    wait_out(lat);
    tick();

    // illegal word under backpressure
    bus.out_ready = 1'b0;
    push(32'h114, 7'h00, 3'd0, 7'h00, 5'd0,
         32'd0, 32'd0, 32'd0, 1'b1);
    issue(32'h0000_0000, 32'h114);
    wait_out(lat);
    chk("ill latency", 32'(lat), 3);
    push(32'h118, 7'h37, 3'd5, 7'h09, 5'd4,
         32'hA000_0008, 32'hA000_0003,
         32'h1234_5000, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h1234_5237;
    bus.in_pc    = 32'h118;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp out_valid", 32'(bus.out_valid), 1);
      chk("bp in_ready", 32'(bus.in_ready), 0);
      chk("bp out_pc", bus.out_pc, 32'h114);
      chk("bp illegal", 32'(bus.out_illegal), 1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("lui issue rf_cs", 32'(rf_cs), 1);
    chk("lui issue rf_ra", 32'(rf_ra), 8);
    wait_out(lat);
    chk("lui latency", 32'(lat), 3);
    tick();

    // reset while holding a bundle
    bus.out_ready = 1'b0;
    issue(32'h0080_00EF, 32'h11C);
    wait_out(lat);
    chk("jal hold", 32'(bus.out_valid), 1);
    rstn = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(bus.out_valid), 0);
    chk("mid rst rf_cs", 32'(rf_cs), 0);
    chk("mid rst out_pc", bus.out_pc, 0);
    chk("mid rst in_ready", 32'(bus.in_ready), 0);
    tick();
    tick();
    chk("mid rst still", 32'(bus.out_valid), 0);
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("rel in_ready", 32'(bus.in_ready), 1);
    chk("rel out_valid", 32'(bus.out_valid), 0);

    repeat (3) tick();
    chk("scoreboard drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_decode.md
# riscv_decode

Decode stage that sits between instruction fetch and execute and is the sole initiator on the `riscv_registers` port. It accepts one 32-bit instruction at a time, extracts fields and the immediate, and issues the register-file read. It captures the registered operands and presents a decoded bundle to execute over a valid/ready handshake. It also arbitrates writeback traffic onto the register file's shared `rd`/`data` write path.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: single clock, all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: decode accepts the instruction.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: PC of the instruction.
- `wb_valid` in 1: writeback request.
- `wb_ready` out 1: writeback accepted this cycle.
- `wb_rd` in 5: destination register.
- `wb_data` in 32: value to write.
- `rf_cs` out 1: register-file access strobe.
- `rf_ra`, `rf_rb`, `rf_rd` out 5 each: register-file addresses.
- `rf_wen` out 1: register-file write enable.
- `rf_data` out 32: write data.
- `rf_a`, `rf_b` in 32: registered read data. Valid the cycle after the `rf_cs` read cycle.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `out_pc` out 32; `out_opcode` out 7; `out_funct3` out 3; `out_funct7` out 7; `out_rd` out 5.
- `out_rs1_val`, `out_rs2_val` out 32; `out_imm` out 32, sign-extended.
- `out_illegal` out 1: the opcode is unsupported or `instr[1:0]` is not `2'b11`.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, HOLD.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`, latch instr/pc and go to ISSUE.
- **ISSUE:**
  - If `wb_valid` is high, perform the write and stay in ISSUE (writeback has priority over the read).
  - Otherwise drive `rf_cs`=1, `rf_wen`=0, `rf_ra`=rs1, `rf_rb`=rs2, `rf_rd`=rd, then go to WAIT.
- **WAIT:**
  - `wb_ready`=0 and `rf_cs`=0.
  - Capture `rf_a`/`rf_b` into the output registers at the end of the cycle and go to HOLD.
  - rs=0 forces the captured operand to 0.
- **HOLD:**
  - `out_valid`=1 and all `out_*` stable.
  - `in_ready`=`out_ready`.
  - When `out_ready` and `in_valid` are both high: latch the new instruction and go to ISSUE.
  - When `out_ready` is high and `in_valid` is low: go to IDLE.
- **Writeback service:**
  - Served in IDLE, ISSUE and HOLD; never in WAIT.
  - A served write drives `rf_cs`=1, `rf_wen`=1, `rf_rd`=`wb_rd`, `rf_data`=`wb_data`, and `rf_ra`/`rf_rb`=0.
  - `wb_ready`=1 in the same cycle.
- **x0 write:** `wb_ready`=1 but `rf_cs`=0, so no write is performed.
- **Unused cycles:** `rf_cs`=0; all `rf_*` buses driven 0.
- **Immediate by opcode:**
  - I-type: LOAD, OP-IMM, JALR, SYSTEM, MISC-MEM.
  - S-type: STORE. B-type: BRANCH.
  - U-type: LUI, AUIPC. J-type: JAL.
  - OP: imm=0.
- **Illegal instructions:** any other opcode sets `out_illegal`=1 with imm=0. The operand read is still performed.

## Timing
- **Reset:**
  - State IDLE; `out_valid`=0, `wb_ready`=0, `rf_cs`=0, `rf_wen`=0.
  - All `out_*` and `rf_*` buses are 0.
  - `in_ready` goes to 1 the first cycle after `rstn` deasserts.
  - Reset mid-operation discards the in-flight instruction.
- **Latency:**
  - Acceptance at edge N gives ISSUE in cycle N+1, WAIT in N+2, and `out_valid` in N+3.
  - Each writeback served in ISSUE adds one cycle.
- **Read-after-write:** a write served in ISSUE completes before the read cycle, so the read returns the new value.
- **Throughput:** one instruction per 3 cycles with back-to-back handshakes in HOLD.
- **Output stability:** `out_*` change only on the WAIT→HOLD edge.

## Structure
- **Package `riscv_pkg`:**
  - Opcode localparams (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111, SYSTEM 1110011).
  - FSM state encoding.
  - Immediate-format enum (I/S/B/U/J/NONE).
- **Sub-module `riscv_imm_gen`:** combinational; inputs instr[31:0], outputs imm[31:0] and illegal.
- **Remaining logic:** the FSM and the registers live in `riscv_decode`.

## Test plan
- **Reset:** hold `rstn` low mid-HOLD, then release. Expect `out_valid`=0 and `rf_cs`=0 during reset, and `in_ready`=1 one cycle after release.
- **ADDI:** preload x1=10 via writeback (`wb_rd`=1). Feed `0xFFD08293` (`addi x5,x1,-3`). Expect in cycle N+3: `out_rs1_val`=10, `out_imm`=0xFFFFFFFD, `out_rd`=5, `out_opcode`=0010011.
- **Collision:** `wb_valid` with `wb_rd`=2, `wb_data`=0x55, held 2 cycles during ISSUE for an instruction reading x2. Expect 2 `wb_ready` pulses with `rf_wen`=1, `out_valid` delayed to N+5, and `out_rs1_val`=0x55.
- **x0:** write x0 with 0xFFFFFFFF. Expect `wb_ready`=1 and `rf_cs`=0. A following `add x3,x0,x0` yields both operands 0.
- **Branch immediate:** feed `0xFE000EE3` (`beq x0,x0,-4`). Expect `out_imm`=0xFFFFFFFC and `out_illegal`=0.
- **Illegal and backpressure:** feed `0x00000000`. Expect `out_illegal`=1. Hold `out_ready` low for 5 cycles: outputs stay stable and `in_ready`=0. Then raise `out_ready` with `in_valid` high: the next instruction is accepted the same cycle.
